matrix_result_streamer: RTL and testbench
=========================================

# matrix_result_streamer

Downstream consumer of the matrix arithmetic engines: once an op such as element-wise add has written its result matrix into BRAM, this block reads that matrix back in row-major order. It presents each element on a valid/ready stream to the display/UART formatting stage. Each element is tagged with end-of-row and end-of-matrix flags. It drives the shared BRAM read port only while busy, and uses the same start/done convention as the op engines.

## Interface
Parameters:
- ELEMENT_WIDTH, default `ELEMENT_WIDTH (matrix_pkg.vh): element bit width.
- ADDR_WIDTH, default `BRAM_ADDR_WIDTH (matrix_pkg.vh): BRAM address width.
- RD_LATENCY, default 2: number of cycles from the mem_rd_en cycle to the cycle after which mem_rd_data is valid. Legal range 1..7.

Ports:
- One clock, `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  level request; sampled only in IDLE.
- done  out  1  high from completion until start is low.
- busy  out  1  high in every state except IDLE and DONE.
- dim_m  in  4  row count; latched at start.
- dim_n  in  4  column count; latched at start.
- addr_base  in  ADDR_WIDTH  address of element (0,0); latched at start.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_rd_addr  out  ADDR_WIDTH  read address.
- mem_rd_data  in  ELEMENT_WIDTH  BRAM read data.
- out_valid  out  1  out_data and flags are valid.
- out_ready  in  1  downstream accepts the element.
- out_data  out  ELEMENT_WIDTH  element value.
- out_row_last  out  1  element is the last one in its row (j == dim_n-1).
- out_last  out  1  element is the last one in the matrix.

## Operation
- Reset values: done=0, busy=0, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_row_last=0, out_last=0. State goes to IDLE and counters i, j go to 0.
- Reset asserted mid-operation aborts immediately: no further reads and no stream output. The downstream side must drop any partial matrix.
- States and transitions:
  - IDLE: if start=1, latch dim_m, dim_n and addr_base, and clear i, j.
    - If the latched dim_m==0 or dim_n==0, go to DONE with no reads.
    - Otherwise go to ISSUE.
  - ISSUE: mem_rd_en=1 for this one cycle; mem_rd_addr = addr_base + i*dim_n + j. Go to WAIT.
  - WAIT: count RD_LATENCY cycles including the ISSUE cycle, then go to CAPTURE.
  - CAPTURE: register mem_rd_data into out_data; set out_row_last and out_last. Go to PRESENT.
  - PRESENT: out_valid=1. On out_valid & out_ready:
    - advance j; on wrap, set j=0 and i=i+1;
    - go to DONE if the element was out_last, otherwise go to ISSUE.
  - DONE: done=1. When start=0, go to IDLE; done falls in the same edge.
- Address arithmetic: i*dim_n is 8 bits unsigned, zero-extended to ADDR_WIDTH. The sum is taken modulo 2^ADDR_WIDTH, so it wraps silently.
- mem_rd_addr holds its last value when mem_rd_en=0.
- While out_valid=1 and out_ready=0, out_data, out_row_last and out_last stay stable.
- start is ignored while busy. A start still held high in DONE does not retrigger the block.

## Timing
- Let cycle S be the cycle in which start is sampled high in IDLE. Then:
  - busy rises at S+1;
  - the first mem_rd_en is at cycle S+1 (registered outputs).
- Let cycle R be a read-strobe cycle:
  - mem_rd_data is captured at the end of cycle R+RD_LATENCY;
  - out_valid is high from cycle R+RD_LATENCY+1.
- Handshake completes at the end of any cycle with out_valid=1 and out_ready=1. out_valid is low in the next cycle, and the next mem_rd_en is in that cycle.
- With out_ready held at 1, the element period is RD_LATENCY+2 cycles (4 cycles at default). The matrix takes m*n*(RD_LATENCY+2) cycles from S+1 to the final handshake.
- done and busy change in the cycle after the last handshake.
- If dims are zero: done=1 at S+1, and mem_rd_en and out_valid never rise.

## Test plan
- 2x3 matrix, addr_base=0x10, RAM[0x10+k]=k+1, out_ready=1. Required response:
  - read addresses 0x10..0x15 in order;
  - out_data 1..6;
  - out_row_last on elements 3 and 6; out_last on element 6 only;
  - done high 24 cycles after S+1 and held until start drops.
- Backpressure: 2x2 with out_ready low for 5 cycles on each element. out_data and flags stay stable while stalled; exactly 4 reads, with no read issued while out_valid=1.
- Degenerate sizes:
  - dim_m=0, dim_n=4: done at S+1 with no reads;
  - 1x1: one read, and the single element has both out_row_last=1 and out_last=1.
- Address wrap: ADDR_WIDTH=8, addr_base=0xFE, 1x4. Required reads at 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-op: assert rst during PRESENT of element 3 of a 3x3. The next cycle shows all outputs at reset values. A new start then streams from (0,0).
- Restart protocol: hold start high through DONE with no second run. Drop start, then raise it again: the second run matches the first.

Source files
------------

// File: rtl/matrix_result_streamer.sv
// Reads an m x n result matrix from BRAM row-major and streams it with row/matrix-end flags.
// One element in flight: period RD_LATENCY+2 cycles; out_valid holds data stable until out_ready.
`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 16
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 10
`endif

module matrix_result_streamer #(
  parameter int ELEMENT_WIDTH = `ELEMENT_WIDTH,
  parameter int ADDR_WIDTH    = `BRAM_ADDR_WIDTH,
  parameter int RD_LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     done,
  output logic                     busy,
  input  logic [3:0]               dim_m,
  input  logic [3:0]               dim_n,
  input  logic [ADDR_WIDTH-1:0]    addr_base,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ELEMENT_WIDTH-1:0] out_data,
  output logic                     out_row_last,
  output logic                     out_last
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_PRESENT, S_DONE
  } state_t;

  state_t                  state, state_nx;
  logic [3:0]              i, j, m_q, n_q;
  logic [3:0]              i_nx, j_nx;
  logic [ADDR_WIDTH-1:0]   base_q, addr_nx;
  logic [7:0]              prod;
  logic [2:0]              wcnt;
  logic                    row_end, hs;

  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign mem_rd_en = (state == S_ISSUE);
  assign out_valid = (state == S_PRESENT);
  assign hs        = out_valid && out_ready;
  assign row_end   = (j == n_q - 4'd1);

  // Position and address of the element following the one being handed off.
  always_comb begin
    i_nx    = row_end ? i + 4'd1 : i;
    j_nx    = row_end ? 4'd0 : j + 4'd1;
    prod    = {4'd0, i_nx} * {4'd0, n_q};
    addr_nx = base_q + ADDR_WIDTH'(prod) + ADDR_WIDTH'(j_nx);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = (dim_m == 4'd0 || dim_n == 4'd0) ? S_DONE : S_ISSUE;
      S_ISSUE:   state_nx = (RD_LATENCY == 1) ? S_CAPTURE : S_WAIT;
      S_WAIT:    if (wcnt == 3'(RD_LATENCY - 1)) state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_PRESENT;
      S_PRESENT: if (out_ready) state_nx = out_last ? S_DONE : S_ISSUE;
      S_DONE:    if (!start) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      i            <= '0;
      j            <= '0;
      m_q          <= '0;
      n_q          <= '0;
      base_q       <= '0;
      wcnt         <= '0;
      mem_rd_addr  <= '0;
      out_data     <= '0;
      out_row_last <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          m_q    <= dim_m;
          n_q    <= dim_n;
          base_q <= addr_base;
          i      <= '0;
          j      <= '0;
          // Address only moves when a read will follow, so it holds otherwise.
          if (dim_m != 4'd0 && dim_n != 4'd0) mem_rd_addr <= addr_base;
        end
        S_ISSUE: wcnt <= 3'd1;
        S_WAIT:  wcnt <= wcnt + 3'd1;
        S_CAPTURE: begin
          out_data     <= mem_rd_data;
          out_row_last <= row_end;
          out_last     <= row_end && (i == m_q - 4'd1);
        end
        S_PRESENT: if (hs) begin
          i <= i_nx;
          j <= j_nx;
          if (!out_last) mem_rd_addr <= addr_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer: BRAM model, read/element scoreboards, table of matrix runs.
module tb_matrix_result_streamer;
  localparam int EW  = 16;
  localparam int AW  = 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst, start, done, busy;
  logic [3:0]    dim_m, dim_n;
  logic [AW-1:0] addr_base, mem_rd_addr;
  logic          mem_rd_en, out_valid, out_ready, out_row_last, out_last;
  logic [EW-1:0] mem_rd_data, out_data;

  always #5 clk = ~clk;

  matrix_result_streamer #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
    .dim_m(dim_m), .dim_n(dim_n), .addr_base(addr_base),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_last(out_row_last), .out_last(out_last)
  );

  // BRAM model: contents ram[a] = a - 15, data valid LAT cycles after the strobe cycle.
  function automatic logic [EW-1:0] ram_val(input logic [AW-1:0] a);
    return EW'(a) - EW'(15);
  endfunction

  logic [EW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= mem_rd_en ? ram_val(mem_rd_addr) : 16'hBAD0;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rd_data = pipe[LAT-1];

  typedef struct packed {
    logic [EW-1:0] d;
    logic          rl;
    logic          l;
  } elem_t;

  typedef struct {
    int m; int n; int base; int stall; int exp_done; int exp_reads;
  } vec_t;

  elem_t         eq[$];
  logic [AW-1:0] aq[$];
  int            checks = 0, errors = 0;
  int            reads_seen = 0, elems_seen = 0, stall_cyc = 0;
  logic          mon_en = 1'b0;

  // Downstream: hold ready low for stall_cyc cycles of each presented element.
  initial begin
    int cnt;
    cnt = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!out_valid) begin
        cnt = 0;
        out_ready = (stall_cyc == 0);
      end else begin
        out_ready = (cnt >= stall_cyc);
        cnt++;
      end
    end
  end

  // Monitor: reads, handshakes and stall stability, sampled mid-cycle.
  initial begin
    logic  prev_stall;
    elem_t prev_e, got, exp_e;
    logic [AW-1:0] exp_a;
    prev_stall = 1'b0;
    prev_e = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        got = {out_data, out_row_last, out_last};
        if (mem_rd_en) begin
          reads_seen++;
          checks++;
          if (out_valid) begin
            errors++;
            $display("FAIL rd_while_valid: read at %0h while out_valid=1", mem_rd_addr);
          end
          checks++;
          if (aq.size() == 0) begin
            errors++;
            $display("FAIL extra_read: addr %0h, no read expected", mem_rd_addr);
          end else begin
            exp_a = aq.pop_front();
            if (mem_rd_addr != exp_a) begin
              errors++;
              $display("FAIL rd_addr: got %0h expected %0h", mem_rd_addr, exp_a);
            end
          end
        end
        if (prev_stall) begin
          checks++;
          if (!out_valid || got != prev_e) begin
            errors++;
            $display("FAIL stable: valid=%0b data/flags %0h expected %0h", out_valid, got, prev_e);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          elems_seen++;
          if (eq.size() == 0) begin
            errors++;
            $display("FAIL extra_elem: got %0h, none expected", got);
          end else begin
            exp_e = eq.pop_front();
            if (got != exp_e) begin
              errors++;
              $display("FAIL elem: data=%0h rl=%0b l=%0b expected data=%0h rl=%0b l=%0b",
                       got.d, got.rl, got.l, exp_e.d, exp_e.rl, exp_e.l);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_e = got;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    logic [29:0] snap;
    snap = {done, busy, mem_rd_en, mem_rd_addr, out_valid, out_data, out_row_last, out_last};
    checks++;
    if (snap != '0) begin
      errors++;
      $display("FAIL %s: outputs %0h expected 0", name, snap);
    end
  endtask

  task automatic load_expect(input vec_t v);
    logic [AW-1:0] a;
    for (int i = 0; i < v.m; i++)
      for (int j = 0; j < v.n; j++) begin
        a = AW'(v.base + i * v.n + j);
        aq.push_back(a);
        eq.push_back({ram_val(a), 1'(j == v.n - 1), 1'((i == v.m - 1) && (j == v.n - 1))});
      end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int k;
    load_expect(v);
    reads_seen = 0;
    elems_seen = 0;
    stall_cyc  = v.stall;
    @(negedge clk);
    dim_m = 4'(v.m);
    dim_n = 4'(v.n);
    addr_base = AW'(v.base);
    start = 1'b1;
    @(negedge clk);
    k = 1;
    checks++;
    if (busy != (v.exp_reads != 0)) begin
      errors++;
      $display("FAIL %s busy_s1: got %0b expected %0b", name, busy, v.exp_reads != 0);
    end
    while (!done && k < 4000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != v.exp_done) begin
      errors++;
      $display("FAIL %s done_cycle: got S+%0d expected S+%0d", name, k, v.exp_done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!done || busy) begin
      errors++;
      $display("FAIL %s done_hold: done=%0b busy=%0b expected 1/0", name, done, busy);
    end
    checks++;
    if (reads_seen != v.exp_reads || aq.size() != 0 || eq.size() != 0) begin
      errors++;
      $display("FAIL %s drain: reads %0d expected %0d, left addr=%0d elem=%0d",
               name, reads_seen, v.exp_reads, aq.size(), eq.size());
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done || busy) begin
      errors++;
      $display("FAIL %s idle_after: done=%0b busy=%0b expected 0/0", name, done, busy);
    end
    aq.delete();
    eq.delete();
  endtask

  vec_t vecs[8];

  initial begin
    vec_t mid;
    int   guard;
    vecs[0] = '{m: 2,  n: 3,  base: 'h10, stall: 0, exp_done: 25,  exp_reads: 6};
    vecs[1] = '{m: 2,  n: 2,  base: 'h30, stall: 5, exp_done: 37,  exp_reads: 4};
    vecs[2] = '{m: 0,  n: 4,  base: 'h50, stall: 0, exp_done: 1,   exp_reads: 0};
    vecs[3] = '{m: 1,  n: 1,  base: 'h77, stall: 0, exp_done: 5,   exp_reads: 1};
    vecs[4] = '{m: 1,  n: 4,  base: 'hFE, stall: 0, exp_done: 17,  exp_reads: 4};
    vecs[5] = '{m: 3,  n: 2,  base: 'h40, stall: 2, exp_done: 37,  exp_reads: 6};
    vecs[6] = '{m: 4,  n: 0,  base: 'h08, stall: 0, exp_done: 1,   exp_reads: 0};
    vecs[7] = '{m: 15, n: 15, base: 'h20, stall: 0, exp_done: 901, exp_reads: 225};

    rst = 1'b1;
    start = 1'b0;
    dim_m = '0;
    dim_n = '0;
    addr_base = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    mon_en = 1'b1;

    for (int t = 0; t < 8; t++) run_vec(vecs[t], $sformatf("vec%0d", t));

    // Abort a 3x3 while its third element is on the stream.
    mid = '{m: 3, n: 3, base: 'h00, stall: 0, exp_done: 37, exp_reads: 9};
    load_expect(mid);
    elems_seen = 0;
    stall_cyc = 0;
    @(negedge clk);
    dim_m = 4'd3;
    dim_n = 4'd3;
    addr_base = '0;
    start = 1'b1;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (!(out_valid && elems_seen == 2) && guard < 200);
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL mid_reach: third element not presented, seen %0d expected 2", elems_seen);
    end
    mon_en = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    aq.delete();
    eq.delete();
    @(negedge clk);
    check_reset_outputs("post_reset_idle");
    mon_en = 1'b1;
    run_vec(mid, "after_reset");

    run_vec(vecs[0], "restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
